// File: rtl/rf_param.sv
// Parameterised register file with two combinational read ports and one write port.
// It runs a post-reset clear sweep. Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module rf_param #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rn1,
  input  logic [AW-1:0] rn2,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] wd,
  input  logic          w,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy,
  output logic          drop
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          wr_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign busy = (state_q == CLEAR);

  always_comb begin
    wr_req = w;
`ifdef RF_ZERO_REG_EN
    // Writes to register 0 are simply ignored, so they never count as dropped.
    wr_req = w & (wn != '0);
`endif
    drop    = wr_req & busy & ~rst;
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = wn;
    wr_data = wd;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          wr_en = wr_req;
        end
        CLEAR: begin
          wr_en   = 1'b1;
          wr_addr = cnt_q;
          wr_data = '0;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == AW'(DEPTH-1)) state_d = IDLE;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset: it is zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd1 = busy ? '0 : mem_q[rn1];
    rd2 = busy ? '0 : mem_q[rn2];
`ifdef RF_ZERO_REG_EN
    if (rn1 == '0) rd1 = '0;
    if (rn2 == '0) rd2 = '0;
`endif
  end

endmodule

// File: tb/tb_rf_param.sv
// Self-checking bench for rf_param (DW=32, AW=5): a behavioural model is compared every cycle,
// plus directed literal checks.
module tb_rf_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rn1 = '0, rn2 = '0, wn = '0;
  logic [DW-1:0] wd = '0;
  logic          w = 1'b0;
  logic [DW-1:0] rd1, rd2;
  logic          busy, drop;

  int n_checks = 0;
  int n_fail   = 0;

  rf_param #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .wn(wn), .wd(wd), .w(w),
    .rd1(rd1), .rd2(rd2), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents array plus number of busy cycles still to run.
  logic [DW-1:0] m_mem [DEPTH];
  int            busy_left = 0;
  bit            chk_en = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

  always @(posedge clk) begin
    if (rst) begin
      busy_left = DEPTH;
      chk_en    = 1'b1;
    end else if (busy_left > 0) begin
      m_mem[DEPTH - busy_left] = '0;
      busy_left--;
    end else if (w && !(ZERO_EN && wn == 0)) begin
      m_mem[wn] = wd;
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (busy_left > 0) return '0;
    if (ZERO_EN && a == 0) return '0;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'b0, busy}, {31'b0, busy_left > 0});
      check("model_drop", {31'b0, drop},
            {31'b0, w && (busy_left > 0) && !rst && !(ZERO_EN && wn == 0)});
      check("model_rd1", rd1, m_read(rn1));
      check("model_rd2", rd2, m_read(rn2));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Counts cycles until busy falls; assumes rst was just deasserted.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (!busy) break;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cyc();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_drop", {31'b0, drop}, 32'd0);
    check("reset_rd1", rd1, 32'd0);
    check("reset_rd2", rd2, 32'd0);

    // Sweep length, read during sweep.
    rst = 1'b0; rn1 = 5'd17;
    #1 check("sweep_rd1_17", rd1, 32'd0);
    count_busy(n);
    check("sweep_len", n, 32'd32);

    // Write attempted during sweep is dropped.
    rst = 1'b1; cyc(); rst = 1'b0;
    cyc(); cyc(); cyc();
    w = 1'b1; wn = 5'd5; wd = 32'hAAAA;
    #1 check("drop_during_sweep", {31'b0, drop}, 32'd1);
    cyc(); w = 1'b0;
    count_busy(n);
    check("sweep2_end", {31'b0, busy}, 32'd0);
    rn1 = 5'd5;
    #1 check("dropped_not_stored", rd1, 32'd0);

    // Fill reg[i] = i*i.
    for (int i = 0; i < DEPTH; i++) begin
      w = 1'b1; wn = AW'(i); wd = DW'(i * i);
      cyc();
    end
    w = 1'b0;
    rn1 = 5'd31; rn2 = 5'd7;
    #1 check("fill_rd1_31", rd1, 32'd961);
    check("fill_rd2_7", rd2, 32'd49);
    rn1 = 5'd0; rn2 = 5'd0;
    #1 check("fill_rd1_0", rd1, 32'd0);
    check("fill_rd2_0", rd2, 32'd0);

    // No bypass on same-cycle read of the write address.
    rn1 = 5'd3; wn = 5'd3; wd = 32'd100; w = 1'b1;
    #1 check("nobypass_before", rd1, 32'd9);
    cyc(); w = 1'b0;
    check("nobypass_after", rd1, 32'd100);

    // Zero register behaviour.
    wn = 5'd0; wd = 32'd123; w = 1'b1;
    #1 check("zero_drop", {31'b0, drop}, 32'd0);
    cyc(); w = 1'b0; rn1 = 5'd0;
    #1 check("zero_reg_rd1", rd1, ZERO_EN ? 32'd0 : 32'd123);

    // Mid-sweep reset restarts the sweep.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("mid_busy_cnt10", {31'b0, busy}, 32'd1);
    rst = 1'b1; cyc();
    check("mid_busy_in_rst", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    count_busy(n);
    check("mid_sweep_len", n, 32'd32);
    rn1 = 5'd31; rn2 = 5'd7;
    #1 check("cleared_rd1_31", rd1, 32'd0);
    check("cleared_rd2_7", rd2, 32'd0);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 Parameter DW, default 32: data width of every register, in bits.
REQ-002 Parameter AW, default 5: address width; the file depth SHALL be DEPTH = 2**AW.
REQ-003 clk  input  1: single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 rn1  input  AW: read address, port 1.
REQ-006 rn2  input  AW: read address, port 2.
REQ-007 wn  input  AW: write address.
REQ-008 wd  input  DW: write data.
REQ-009 w  input  1: write enable.
REQ-010 rd1  output  DW: read data, port 1.
REQ-011 rd2  output  DW: read data, port 2.
REQ-012 busy  output  1: clear sweep in progress.
REQ-013 drop  output  1: combinational flag; high when a requested write is being discarded this cycle.

Function
REQ-014 Storage SHALL be DEPTH registers of DW bits each.
REQ-015 Reads SHALL be combinational: rd1 = reg[rn1] and rd2 = reg[rn2] when busy=0; both ports are independent and may address the same register.
REQ-016 While busy=1, rd1 and rd2 SHALL read 0 regardless of rn1/rn2.
REQ-017 Writes: on a rising edge with rst=0, busy=0 and w=1, reg[wn] SHALL take wd; with w=0, no register changes.
REQ-018 Same-cycle read of wn SHALL return the old value before the edge and wd after it (no bypass).
REQ-019 The FSM SHALL have two states: IDLE (busy=0) and CLEAR (busy=1).
REQ-020 Any edge with rst=1 SHALL set state to CLEAR and sweep counter cnt (AW bits) to 0, from either state.
REQ-021 In CLEAR with rst=0, each edge SHALL write reg[cnt] <= 0 and cnt <= cnt+1; the edge that clears cnt = DEPTH-1 SHALL return the FSM to IDLE.
REQ-022 Therefore busy SHALL stay high for exactly DEPTH clock cycles after rst deasserts.
REQ-023 drop SHALL equal w & busy & ~rst; dropped writes SHALL never modify storage.
REQ-024 rst asserted mid-sweep SHALL restart the sweep from cnt=0, giving a full DEPTH cycles of busy after rst deasserts.
REQ-025 cnt SHALL not wrap or advance in IDLE.

Reset
REQ-026 The rst edge itself SHALL leave register contents unchanged; contents are zeroed only by the sweep.
REQ-027 After reset: busy=1, drop=0 (when w=0), and rd1=rd2=0.
REQ-028 Register contents before the first reset are undefined; the bench SHALL reset before use.

Configuration
REQ-029 Macro RF_ZERO_REG_EN, when defined: reads of address 0 SHALL return 0 on both ports.
REQ-030 With RF_ZERO_REG_EN defined, writes to wn=0 SHALL be ignored and SHALL NOT raise drop.
REQ-031 Without RF_ZERO_REG_EN, register 0 SHALL behave as an ordinary register.

Verification (DW=32, AW=5)
REQ-032 Sweep length: rst high 1 cycle, then low -> busy=1 for exactly 32 cycles, then 0; rn1=17 gives rd1=0.
REQ-033 Fill and read, macro undefined: after the sweep, write reg[i]=i*i for i=0..31; then rn1=31, rn2=7 -> rd1=961, rd2=49; rn1=rn2=0 -> both 0.
REQ-034 Write during sweep: during the sweep, w=1, wn=5, wd=32'hAAAA -> drop=1 that cycle; after busy falls, rn1=5 -> rd1=0.
REQ-035 No bypass: reg[3]=9, rn1=wn=3, wd=100, w=1 -> rd1=9 before the edge and 100 after.
REQ-036 Mid-sweep reset: rst reasserted when cnt=10 -> busy stays 1, then 32 more cycles of busy after rst deasserts.
REQ-037 Zero register: wn=0, wd=123, w=1, then rn1=0 -> rd1=0 with RF_ZERO_REG_EN defined, 123 without.
